// File: rtl/approx_mult_if.sv
// Operand/result streaming bus for approx_mult_pipe: operand handshake in, product handshake out.
interface approx_mult_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   z;
    logic             z_mode;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, z, z_mode, op_count
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, z, z_mode, op_count
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned multiplier with per-operation exact/approximate mode; the approximate
// mode drops the low L multiplier rows and adds an OR-compressed column compensation term.
module approx_mult_pipe #(
    parameter int unsigned W      = 8,
    parameter int unsigned L      = 2,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    approx_mult_if.slave  bus
);
    localparam int unsigned ZW   = 2 * W;
    localparam int unsigned HW   = W - L;
    localparam int unsigned LAST = STAGES - 1;

    logic [HW-1:0]    w_x_hi;
    logic [ZW-1:0]    w_comp;
    logic [ZW-1:0]    w_exact;
    logic [ZW-1:0]    w_approx;
    logic [ZW-1:0]    w_z;
    logic             w_adv;

    logic             r_vld [STAGES];
    logic [ZW-1:0]    r_z   [STAGES];
    logic             r_md  [STAGES];
    logic [CNT_W-1:0] r_cnt;

    assign w_x_hi   = bus.x[W-1:L];
    assign w_exact  = ZW'(bus.x) * ZW'(bus.y);
    assign w_approx = ((ZW'(bus.y) * ZW'(w_x_hi)) << L) + w_comp;
    assign w_z      = bus.mode ? w_approx : w_exact;

    // Dropped rows: only columns W-1 and up survive, each collapsed to a single OR bit.
    always_comb begin
        w_comp = '0;
        for (int unsigned i = 0; i < L; i++) begin
            for (int unsigned j = 0; j < W; j++) begin
                if (i + j >= W - 1) begin
                    w_comp[i + j] = w_comp[i + j] | (bus.x[i] & bus.y[j]);
                end
            end
        end
    end

    // One global advance: the whole pipe moves whenever the output slot is free or draining.
    assign w_adv = bus.out_ready || !r_vld[LAST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_z[s]   <= '0;
                r_md[s]  <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld[0] <= bus.in_valid;
            r_z[0]   <= w_z;
            r_md[0]  <= bus.mode;
            for (int unsigned s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_z[s]   <= r_z[s-1];
                r_md[s]  <= r_md[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_vld[LAST] && bus.out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[LAST];
    assign bus.z         = r_z[LAST];
    assign bus.z_mode    = r_md[LAST];
    assign bus.op_count  = r_cnt;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Bench for approx_mult_pipe: two configurations (W8/L2/S2 and W12/L4/S3 with 4-bit counter)
// driven by directed and random streams, scored against an arithmetic reference in order.
module tb_approx_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    approx_mult_if #(.W(8),  .CNT_W(16)) if_a ();
    approx_mult_if #(.W(12), .CNT_W(4))  if_b ();

    approx_mult_pipe #(.W(8), .L(2), .STAGES(2), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a));
    approx_mult_pipe #(.W(12), .L(4), .STAGES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b));

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    bit          a_v = 0, a_m = 0, a_or = 1;
    logic [7:0]  a_x = '0, a_y = '0;
    bit          b_v = 0, b_m = 0, b_or = 1;
    logic [11:0] b_x = '0, b_y = '0;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    int unsigned cnt_a = 0, cnt_b = 0, acc_a = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Row-by-row sum of the kept partial products plus the OR-compressed low columns.
    function automatic logic [31:0] ref_mult(input int w, input int l, input logic [15:0] x,
                                             input logic [15:0] y, input logic m);
        longint acc = 0;
        if (!m) return 32'(longint'(x) * longint'(y));
        for (int i = l; i < w; i++)
            if (x[i]) acc += longint'(y) << i;
        for (int k = w - 1; k <= w + l - 2; k++) begin
            bit b = 0;
            for (int i = 0; i < l; i++)
                if (k - i <= w - 1 && x[i] && y[k - i]) b = 1;
            if (b) acc += longint'(1) << k;
        end
        return 32'(acc);
    endfunction

    task automatic apply();
        if_a.in_valid = a_v; if_a.x = a_x; if_a.y = a_y; if_a.mode = a_m; if_a.out_ready = a_or;
        if_b.in_valid = b_v; if_b.x = b_x; if_b.y = b_y; if_b.mode = b_m; if_b.out_ready = b_or;
    endtask

    // Drive on the falling edge, then score the handshakes that the next rising edge will take.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        apply();
        #1;
        if (!rst) begin
            check("a_cnt", 64'(if_a.op_count), 64'(cnt_a % 65536));
            check("b_cnt", 64'(if_b.op_count), 64'(cnt_b % 16));
            if (if_a.in_valid && if_a.in_ready) begin
                qa.push_back({if_a.mode, ref_mult(8, 2, 16'(if_a.x), 16'(if_a.y), if_a.mode)});
                acc_a++;
            end
            if (if_b.in_valid && if_b.in_ready)
                qb.push_back({if_b.mode, ref_mult(12, 4, 16'(if_b.x), 16'(if_b.y), if_b.mode)});
            if (if_a.out_valid && if_a.out_ready) begin
                if (qa.size() == 0) check("a_spurious_out", 64'(if_a.out_valid), 64'(0));
                else begin
                    e = qa.pop_front();
                    check("a_z", 64'(if_a.z), 64'(e[31:0]));
                    check("a_zmode", 64'(if_a.z_mode), 64'(e[32]));
                end
                cnt_a++;
            end
            if (if_b.out_valid && if_b.out_ready) begin
                if (qb.size() == 0) check("b_spurious_out", 64'(if_b.out_valid), 64'(0));
                else begin
                    e = qb.pop_front();
                    check("b_z", 64'(if_b.z), 64'(e[31:0]));
                    check("b_zmode", 64'(if_b.z_mode), 64'(e[32]));
                end
                cnt_b++;
            end
        end
    endtask

    task automatic drain();
        a_v = 0; b_v = 0; a_or = 1; b_or = 1;
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        tick();
        check("a_drained", 64'(qa.size()), 64'(0));
        check("b_drained", 64'(qb.size()), 64'(0));
    endtask

    // Single isolated op on A with out_ready high: result must show exactly two cycles later.
    task automatic run_a(input logic [7:0] x, input logic [7:0] y, input bit m,
                         input logic [15:0] exp);
        a_v = 1; a_x = x; a_y = y; a_m = m; a_or = 1;
        tick();
        a_v = 0;
        tick();
        check("a_lat_early", 64'(if_a.out_valid), 64'(0));
        tick();
        check("a_lat_valid", 64'(if_a.out_valid), 64'(1));
        check("a_direct_z", 64'(if_a.z), 64'(exp));
        check("a_direct_mode", 64'(if_a.z_mode), 64'(m));
    endtask

    initial begin
        logic [15:0] z_hold;
        bit          held;
        apply();
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_vld", 64'(if_a.out_valid), 64'(0));
        check("rst_a_z", 64'(if_a.z), 64'(0));
        check("rst_a_zmode", 64'(if_a.z_mode), 64'(0));
        check("rst_a_cnt", 64'(if_a.op_count), 64'(0));
        check("rst_a_rdy", 64'(if_a.in_ready), 64'(1));
        check("rst_b_vld", 64'(if_b.out_valid), 64'(0));
        check("rst_b_cnt", 64'(if_b.op_count), 64'(0));
        @(negedge clk);
        rst = 0;

        run_a(8'd255, 8'd255, 1'b0, 16'd65025);
        tick();
        check("a_cnt_first", 64'(if_a.op_count), 64'(1));
        run_a(8'd255, 8'd255, 1'b1, 16'd64644);
        run_a(8'd3, 8'd200, 1'b1, 16'd384);
        run_a(8'd3, 8'd200, 1'b0, 16'd600);
        run_a(8'd0, 8'd123, 1'b1, 16'd0);
        run_a(8'd77, 8'd0, 1'b1, 16'd0);
        run_a(8'd0, 8'd99, 1'b0, 16'd0);
        drain();

        // Mixed modes back-to-back on the same operands.
        a_or = 1; a_x = 8'd170; a_y = 8'd85;
        for (int t = 0; t < 10; t++) begin
            a_v = (t < 8); a_m = t[0];
            tick();
            if (if_a.out_valid)
                check("a_mixed_z", 64'(if_a.z), 64'(if_a.z_mode ? 16'd14408 : 16'd14450));
        end
        drain();

        // Bubble at the output lets the pipe fill even with out_ready low.
        a_or = 0; a_v = 1; a_x = 8'd17; a_y = 8'd33; a_m = 0;
        tick();
        check("a_bubble_rdy0", 64'(if_a.in_ready), 64'(1));
        a_v = 0;
        tick();
        check("a_bubble_rdy1", 64'(if_a.in_ready), 64'(1));
        tick();
        check("a_bubble_vld", 64'(if_a.out_valid), 64'(1));
        check("a_bubble_stall", 64'(if_a.in_ready), 64'(0));
        drain();

        // Six pairs with a five-cycle output stall.
        acc_a = 0; held = 0; z_hold = '0;
        for (int t = 0; t < 16; t++) begin
            a_v = (acc_a < 6); a_x = 8'($urandom); a_y = 8'($urandom); a_m = 1'($urandom);
            a_or = !(t >= 3 && t <= 7);
            tick();
            if (if_a.out_valid && !if_a.out_ready) begin
                check("a_stall_rdy", 64'(if_a.in_ready), 64'(0));
                if (held) check("a_stall_z", 64'(if_a.z), 64'(z_hold));
                z_hold = if_a.z;
                held = 1;
            end else held = 0;
        end
        check("a_stream_acc", 64'(acc_a), 64'(6));
        drain();

        // Counter wrap on the 4-bit instance.
        b_or = 1;
        for (int i = 0; i < 17; i++) begin
            b_v = 1; b_x = 12'($urandom); b_y = 12'($urandom); b_m = 1'($urandom);
            tick();
        end
        drain();
        check("b_wrap", 64'(if_b.op_count), 64'(1));

        // Reset with operations in flight.
        a_or = 1; a_v = 1; a_x = 8'd200; a_y = 8'd201; a_m = 0;
        b_or = 1; b_v = 1; b_x = 12'd4000; b_y = 12'd3000; b_m = 1;
        tick();
        tick();
        a_v = 0; b_v = 0;
        @(negedge clk);
        rst = 1;
        apply();
        #1;
        check("mid_rst_a_vld", 64'(if_a.out_valid), 64'(0));
        check("mid_rst_a_cnt", 64'(if_a.op_count), 64'(0));
        check("mid_rst_b_vld", 64'(if_b.out_valid), 64'(0));
        check("mid_rst_b_cnt", 64'(if_b.op_count), 64'(0));
        qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_a_vld", 64'(if_a.out_valid), 64'(0));
            check("post_rst_b_vld", 64'(if_b.out_valid), 64'(0));
        end

        // Random traffic with random back-pressure on both configurations.
        for (int i = 0; i < 10000; i++) begin
            a_v = ($urandom_range(0, 3) != 0); a_or = ($urandom_range(0, 3) != 0);
            a_x = 8'($urandom); a_y = 8'($urandom); a_m = 1'($urandom);
            b_v = ($urandom_range(0, 3) != 0); b_or = ($urandom_range(0, 3) != 0);
            b_x = 12'($urandom); b_y = 12'($urandom); b_m = 1'($urandom);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
